// File: rtl/multicycle_seq_pkg.sv
// rtl/multicycle_seq_pkg.sv - state encoding, opcode classes and trap causes for the sequencer
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM    = 2'b10,
    CAUSE_DMEM    = 2'b11
  } cause_t;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_seq_if.sv
// rtl/multicycle_seq_if.sv - control, memory handshake and status bundle of the sequencer
interface multicycle_seq_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             step;
  logic [4:0]       op;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_we;
  logic             pc_we;
  logic             reg_we;
  logic             busy;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  run, step, op, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we,
           busy, trap, trap_cause, retired
  );

  modport master (
    output run, step, op, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we,
           busy, trap, trap_cause, retired
  );
endinterface

// File: rtl/multicycle_seq_wait_timer.sv
// rtl/multicycle_seq_wait_timer.sv - 8-bit wait counter flagging the TIMEOUT-th consecutive stall
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // cnt_q holds stalls already seen, so the current stall is the last one at TIMEOUT-1
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - multi-cycle RV32I control sequencer with run/step, traps and retire count
module multicycle_seq
  import seq_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input logic           clock,
  input logic           reset,
  multicycle_seq_if.slave bus
);

  state_t           state_q, state_d;
  logic             trap_q, trap_d;
  cause_t           cause_q, cause_d;
  logic [CNT_W-1:0] retired_q;

  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic tmr_en, tmr_clr, tmr_exp;
  state_t boundary;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  assign boundary = bus.run ? S_FETCH : S_IDLE;
  assign tmr_clr  = (state_d != state_q);

  always_comb begin
    state_d  = state_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run || bus.step) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_exp) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_IMEM;
          end
        end
      end
      S_DECODE: begin
        if (op_legal(bus.op)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (bus.op == OP_LOAD || bus.op == OP_STORE) begin
          state_d = S_MEM;
        end else if (bus.op == OP_BRANCH) begin
          pc_we   = 1'b1;
          state_d = boundary;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (bus.op == OP_STORE);
        if (bus.dmem_ready) begin
          if (bus.op == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = boundary;
          end else begin
            state_d = S_WB;
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_exp) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_DMEM;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = boundary;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      if (pc_we) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.reg_we     = reg_we;
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// tb/tb_multicycle_seq.sv - directed self-checking bench for multicycle_seq
module tb_multicycle_seq;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   dreq_cnt;

  multicycle_seq_if #(.CNT_W(32)) bus ();

  multicycle_seq #(.TIMEOUT(15), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // strobe vector order: {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we}
  localparam logic [5:0] ST_NONE  = 6'b000000;
  localparam logic [5:0] ST_FETCH = 6'b100000;
  localparam logic [5:0] ST_IR    = 6'b100100;
  localparam logic [5:0] ST_WB    = 6'b000011;
  localparam logic [5:0] ST_LDM   = 6'b010000;
  localparam logic [5:0] ST_STM   = 6'b011010;
  localparam logic [5:0] ST_BR    = 6'b000010;

  function automatic logic [5:0] strb();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.reg_we};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.run = 1'b0; bus.step = 1'b0; bus.op = 5'b01100;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    chk("rst_strobes", 32'(strb()), 32'(ST_NONE));
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_trap", 32'(bus.trap), 0);
    chk("rst_cause", 32'(bus.trap_cause), 0);
    chk("rst_retired", bus.retired, 0);
    @(negedge clock); reset = 1'b1; #1;
    chk("idle_busy", 32'(bus.busy), 0);

    // ALU stream, ready tied high; run drops during the third EXEC
    @(negedge clock);
    bus.run = 1'b1; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.op = 5'b01100;
    #1; chk("alu_idle_busy", 32'(bus.busy), 0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 11) bus.run = 1'b0;
      #1;
      chk("alu_strobes", 32'(strb()),
          32'((c % 4 == 1) ? ST_IR : (c % 4 == 0) ? ST_WB : ST_NONE));
      chk("alu_retired", bus.retired, 32'((c - 1) / 4));
      chk("alu_busy", 32'(bus.busy), 1);
    end
    @(negedge clock); #1;
    chk("alu_end_busy", 32'(bus.busy), 0);
    chk("alu_end_retired", bus.retired, 3);

    // load with dmem_ready arriving on the 4th MEM cycle
    @(negedge clock);
    bus.run = 1'b1; bus.op = 5'b00000; bus.dmem_ready = 1'b0;
    dreq_cnt = 0;
    for (int r = 1; r <= 8; r++) begin
      @(negedge clock);
      bus.dmem_ready = (r == 7);
      if (r == 8) bus.run = 1'b0;
      #1;
      if (bus.dmem_req) dreq_cnt++;
      chk("ld_strobes", 32'(strb()),
          32'((r == 1) ? ST_IR : (r >= 4 && r <= 7) ? ST_LDM : (r == 8) ? ST_WB : ST_NONE));
    end
    chk("ld_dreq_cycles", dreq_cnt, 4);
    @(negedge clock); bus.dmem_ready = 1'b1; #1;
    chk("ld_retired", bus.retired, 4);
    chk("ld_idle", 32'(bus.busy), 0);

    // store, zero wait
    @(negedge clock);
    bus.run = 1'b1; bus.op = 5'b01000;
    for (int r = 1; r <= 4; r++) begin
      @(negedge clock);
      if (r == 4) bus.run = 1'b0;
      #1;
      chk("st_strobes", 32'(strb()),
          32'((r == 1) ? ST_IR : (r == 4) ? ST_STM : ST_NONE));
    end
    @(negedge clock); #1;
    chk("st_retired", bus.retired, 5);

    // branch
    @(negedge clock);
    bus.run = 1'b1; bus.op = 5'b11000;
    for (int r = 1; r <= 3; r++) begin
      @(negedge clock);
      if (r == 3) bus.run = 1'b0;
      #1;
      chk("br_strobes", 32'(strb()),
          32'((r == 1) ? ST_IR : (r == 3) ? ST_BR : ST_NONE));
    end
    @(negedge clock); #1;
    chk("br_retired", bus.retired, 6);
    chk("br_idle", 32'(bus.busy), 0);

    // single step with run low
    @(negedge clock);
    bus.step = 1'b1; bus.op = 5'b01100;
    for (int r = 1; r <= 4; r++) begin
      @(negedge clock);
      bus.step = 1'b0;
      #1;
      chk("step_strobes", 32'(strb()),
          32'((r == 1) ? ST_IR : (r == 4) ? ST_WB : ST_NONE));
    end
    repeat (2) begin
      @(negedge clock); #1;
      chk("step_idle", 32'(bus.busy), 0);
      chk("step_retired", bus.retired, 7);
    end

    // asynchronous reset in the middle of a stalled load
    @(negedge clock);
    bus.run = 1'b1; bus.op = 5'b00000; bus.dmem_ready = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    chk("mid_mem_dreq", 32'(bus.dmem_req), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_dreq", 32'(bus.dmem_req), 0);
    chk("async_rst_retired", bus.retired, 0);
    chk("async_rst_busy", 32'(bus.busy), 0);
    @(negedge clock); reset = 1'b1; bus.run = 1'b0; #1;

    // imem_ready arrives exactly on the 15th FETCH cycle
    @(negedge clock);
    bus.run = 1'b1; bus.op = 5'b01100; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b1;
    for (int r = 1; r <= 18; r++) begin
      @(negedge clock);
      bus.imem_ready = (r == 15);
      if (r == 16) bus.run = 1'b0;
      #1;
      chk("late_ir_strobes", 32'(strb()),
          32'((r < 15) ? ST_FETCH : (r == 15) ? ST_IR : (r == 18) ? ST_WB : ST_NONE));
      chk("late_ir_trap", 32'(bus.trap), 0);
    end
    @(negedge clock); #1;
    chk("late_ir_retired", bus.retired, 1);

    // imem timeout
    @(negedge clock);
    bus.run = 1'b1; bus.imem_ready = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      @(negedge clock); #1;
      chk("imem_to_strobes", 32'(strb()), 32'((r <= 15) ? ST_FETCH : ST_NONE));
      chk("imem_to_trap", 32'(bus.trap), 32'(r == 16));
    end
    chk("imem_to_cause", 32'(bus.trap_cause), 32'(2'b10));
    chk("imem_to_busy", 32'(bus.busy), 0);
    @(negedge clock); reset = 1'b0; #1;
    chk("imem_to_clear", 32'(bus.trap), 0);
    @(negedge clock); reset = 1'b1; bus.run = 1'b0;

    // illegal opcode, then run/step activity must not disturb the trap
    @(negedge clock);
    bus.run = 1'b1; bus.op = 5'b11111; bus.imem_ready = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      @(negedge clock); #1;
      chk("ill_strobes", 32'(strb()), 32'((r == 1) ? ST_IR : ST_NONE));
      chk("ill_trap", 32'(bus.trap), 32'(r == 3));
    end
    chk("ill_cause", 32'(bus.trap_cause), 32'(2'b01));
    for (int r = 4; r <= 8; r++) begin
      @(negedge clock);
      bus.run  = r[0];
      bus.step = (r == 6);
      #1;
      chk("ill_sticky_trap", 32'(bus.trap), 1);
      chk("ill_sticky_cause", 32'(bus.trap_cause), 32'(2'b01));
      chk("ill_sticky_strobes", 32'(strb()), 32'(ST_NONE));
      chk("ill_sticky_busy", 32'(bus.busy), 0);
    end
    @(negedge clock); reset = 1'b0; bus.step = 1'b0; bus.run = 1'b0; #1;
    chk("ill_clear_trap", 32'(bus.trap), 0);
    chk("ill_clear_cause", 32'(bus.trap_cause), 0);
    @(negedge clock); reset = 1'b1;

    // dmem timeout on a load
    @(negedge clock);
    bus.run = 1'b1; bus.op = 5'b00000; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    for (int r = 1; r <= 19; r++) begin
      @(negedge clock); #1;
      chk("dmem_to_strobes", 32'(strb()),
          32'((r == 1) ? ST_IR : (r >= 4 && r <= 18) ? ST_LDM : ST_NONE));
      chk("dmem_to_trap", 32'(bus.trap), 32'(r == 19));
    end
    chk("dmem_to_cause", 32'(bus.trap_cause), 32'(2'b11));
    chk("dmem_to_retired", bus.retired, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
